// File: rtl/sqrt_reconstruct.sv
// rtl/sqrt_reconstruct.sv - rebuilds rad = root*root + rem with a one-bit-per-cycle shift-add multiply
module sqrt_reconstruct #(
  parameter int DATAWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [DATAWIDTH-1:0]   root,
  input  logic [DATAWIDTH-1:0]   rem,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [2*DATAWIDTH-1:0] rad,
  output logic                   o_rem_err,
  output logic                   o_ovf
);

  localparam int W2 = 2 * DATAWIDTH;
  localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [W2-1:0]          mcand;
  logic [W2-1:0]          acc;
  logic [W2-1:0]          acc_sum;
  logic [W2-1:0]          rad_r;
  logic [DATAWIDTH-1:0]   mult;
  logic [CW-1:0]          count;
  logic                   rem_err_r;
  logic                   rem_err_out;
  logic                   ovf_r;
  logic                   accept;
  logic                   last_iter;

  // Handshake flags and the partial-product add for the current multiplier bit.
  always_comb begin
    i_ready   = (state == IDLE) && !rst;
    o_valid   = (state == DONE);
    accept    = i_valid && i_ready;
    last_iter = (state == BUSY) && (count == LAST);
    acc_sum   = mult[0] ? (acc + mcand) : acc;
  end

  // Next-state logic: a fixed DATAWIDTH iterations in BUSY, then hold in DONE until consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (o_ready)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: load operands on accept, shift-add in BUSY, capture results on the final iteration
  // so the outputs stay frozen through DONE and after consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand       <= '0;
      mult        <= '0;
      acc         <= '0;
      count       <= '0;
      rem_err_r   <= 1'b0;
      rad_r       <= '0;
      ovf_r       <= 1'b0;
      rem_err_out <= 1'b0;
    end else begin
      if (accept) begin
        mcand     <= {{DATAWIDTH{1'b0}}, root};
        mult      <= root;
        acc       <= {{DATAWIDTH{1'b0}}, rem};
        rem_err_r <= ({1'b0, rem} > {root, 1'b0});
        count     <= '0;
      end else if (state == BUSY) begin
        acc   <= acc_sum;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        count <= count + CW'(1);
        if (last_iter) begin
          rad_r       <= acc_sum;
          ovf_r       <= |acc_sum[W2-1:DATAWIDTH];
          rem_err_out <= rem_err_r;
        end
      end
    end
  end

  // Registered result outputs.
  always_comb begin
    rad       = rad_r;
    o_ovf     = ovf_r;
    o_rem_err = rem_err_out;
  end

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// tb/tb_sqrt_reconstruct.sv - randomized and directed self-check of sqrt_reconstruct against an arithmetic model
module tb_sqrt_reconstruct;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid;
  logic           i_ready;
  logic [N-1:0]   root;
  logic [N-1:0]   rem;
  logic           o_valid;
  logic           o_ready;
  logic [2*N-1:0] rad;
  logic           o_rem_err;
  logic           o_ovf;

  int n_cmp = 0;
  int n_err = 0;

  sqrt_reconstruct #(.DATAWIDTH(N)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .root(root), .rem(rem), .o_valid(o_valid), .o_ready(o_ready),
    .rad(rad), .o_rem_err(o_rem_err), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: accept, measure latency, check result, hold for `hold` cycles, then consume.
  task automatic run_op(input int r, input int m, input int hold, input bit pulse);
    int exp_rad;
    int exp_ovf;
    int exp_err;
    int k;
    exp_rad = r * r + m;
    exp_ovf = (exp_rad >= (1 << N)) ? 1 : 0;
    exp_err = (m > 2 * r) ? 1 : 0;

    check("idle_ready", 32'(i_ready), 1);
    root    = N'(r);
    rem     = N'(m);
    i_valid = 1'b1;
    o_ready = (hold == 0);
    tick();
    i_valid = 1'b0;
    root    = N'($urandom);
    rem     = N'($urandom);
    check("busy_ready", 32'(i_ready), 0);

    k = 0;
    while (!o_valid && k < 40) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(N));
    check("rad", 32'(rad), 32'(exp_rad));
    check("ovf", 32'(o_ovf), 32'(exp_ovf));
    check("rem_err", 32'(o_rem_err), 32'(exp_err));

    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        i_valid = 1'b1;
        root    = N'(2);
        rem     = '0;
      end
      tick();
      i_valid = 1'b0;
      check("hold_valid", 32'(o_valid), 1);
      check("hold_rad", 32'(rad), 32'(exp_rad));
      check("hold_ready", 32'(i_ready), 0);
    end

    o_ready = 1'b1;
    tick();
    check("post_valid", 32'(o_valid), 0);
    check("post_ready", 32'(i_ready), 1);
    check("post_rad", 32'(rad), 32'(exp_rad));
    check("post_ovf", 32'(o_ovf), 32'(exp_ovf));
  endtask

  initial begin
    int seen;
    rst     = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    root    = '0;
    rem     = '0;
    tick();
    tick();
    check("rst_ready", 32'(i_ready), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_rad", 32'(rad), 0);
    check("rst_ovf", 32'(o_ovf), 0);
    check("rst_err", 32'(o_rem_err), 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(i_ready), 1);

    run_op(11, 0, 0, 1'b0);
    run_op(15, 30, 0, 1'b0);
    run_op(16, 0, 1, 1'b0);
    run_op(3, 7, 0, 1'b0);
    run_op(0, 1, 2, 1'b0);
    run_op(255, 255, 0, 1'b0);
    run_op(12, 5, 5, 1'b1);

    // Reset landing on the third BUSY edge discards the operation.
    root    = N'(9);
    rem     = N'(3);
    i_valid = 1'b1;
    o_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(i_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_rad", 32'(rad), 0);
    check("midrst_ovf", 32'(o_ovf), 0);
    check("midrst_err", 32'(o_rem_err), 0);
    check("midrst_ready_after", 32'(i_ready), 1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_valid) seen++;
    end
    check("midrst_no_output", 32'(seen), 0);
    run_op(7, 2, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int r;
      int m;
      r = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) m = int'($urandom_range(0, (2 * r > 255) ? 255 : 2 * r));
      else m = int'($urandom_range(0, 255));
      run_op(r, m, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
